fifo_almost_full: RTL and testbench

- First-word fall-through (FWFT) FIFO with an early-warning full flag. if_full_n drops GRACE_PERIOD entries before true capacity. Writes are still accepted until the storage is really full.
- Used on inter-task streams where the producer is pipelined and cannot stop on the same cycle. The pipeline registers inserted by floorplanning add write latency, and the grace slots absorb the in-flight words.
- Generalises the plain FIFO with three additions: a configurable almost-full margin, any DEPTH up to 2^ADDR_WIDTH (not only powers of two), and an occupancy count output.

---
 rtl/fifo_almost_full.sv | 90 +++++++++
 tb/tb_fifo_almost_full.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_almost_full.sv
// rtl/fifo_almost_full.sv - FWFT FIFO with early almost-full flag, arbitrary DEPTH and occupancy count.
// Optional macro FIFO_OVERFLOW_CHECK_EN enables the sticky if_overflow protocol-error flag.
module fifo_almost_full #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 32,
  parameter int GRACE_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_count,
  output logic                  if_overflow
);

  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(DEPTH - GRACE_PERIOD);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr;
  logic                  rd;

  assign wr = if_write & if_write_ce & (count < CNT_FULL);
  assign rd = if_read  & if_read_ce  & (count > CNT_ZERO);

  // Storage is deliberately left unreset; if_dout is masked while empty.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= if_din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      end
      if (rd) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end
      if (wr && !rd) begin
        count <= count + CNT_ONE;
      end else if (rd && !wr) begin
        count <= count - CNT_ONE;
      end
    end
  end

  assign if_empty_n = (count != CNT_ZERO);
  assign if_full_n  = (count < CNT_AF);
  assign if_count   = count;
  assign if_dout    = if_empty_n ? mem[rd_ptr] : '0;

`ifdef FIFO_OVERFLOW_CHECK_EN
  logic overflow_q;

  // Sticky until reset: write into a full FIFO or read from an empty one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if ((if_write && if_write_ce && count == CNT_FULL) ||
                 (if_read && if_read_ce && count == CNT_ZERO)) begin
      overflow_q <= 1'b1;
    end
  end

  assign if_overflow = overflow_q;
`else
  assign if_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_almost_full.sv
// tb/tb_fifo_almost_full.sv - scoreboard bench for fifo_almost_full (DEPTH=32 and DEPTH=5 instances).
module tb_fifo_almost_full;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        a_full_n, a_empty_n, a_overflow;
  logic        a_write_ce = 1'b1, a_write = 1'b0, a_read_ce = 1'b1, a_read = 1'b0;
  logic [31:0] a_din = '0, a_dout;
  logic [5:0]  a_count;

  logic        b_full_n, b_empty_n, b_overflow;
  logic        b_write = 1'b0, b_read = 1'b0;
  logic [31:0] b_din = '0, b_dout;
  logic [3:0]  b_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  fifo_almost_full #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .GRACE_PERIOD(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .if_full_n(a_full_n), .if_write_ce(a_write_ce),
    .if_write(a_write), .if_din(a_din), .if_empty_n(a_empty_n), .if_read_ce(a_read_ce),
    .if_read(a_read), .if_dout(a_dout), .if_count(a_count), .if_overflow(a_overflow)
  );

  fifo_almost_full #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(5), .GRACE_PERIOD(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .if_full_n(b_full_n), .if_write_ce(1'b1),
    .if_write(b_write), .if_din(b_din), .if_empty_n(b_empty_n), .if_read_ce(1'b1),
    .if_read(b_read), .if_dout(b_dout), .if_count(b_count), .if_overflow(b_overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors pop the scoreboard whenever a real pop is about to happen.
  always @(negedge clk) begin
    if (a_read && a_read_ce && a_empty_n) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_pop: got 0x%0h expected no data (scoreboard empty)", a_dout);
      end else begin
        check("a_dout", {32'h0, a_dout}, {32'h0, qa.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (b_read && b_empty_n) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_pop: got 0x%0h expected no data (scoreboard empty)", b_dout);
      end else begin
        check("b_dout", {32'h0, b_dout}, {32'h0, qb.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty_n", a_empty_n, 0);
    check("rst_full_n", a_full_n, 1);
    check("rst_count", a_count, 0);
    check("rst_dout", a_dout, 0);
    check("rst_overflow", a_overflow, 0);
    reset_n = 1'b1;

    // Single write, 1-cycle FWFT latency, then read it back.
    @(posedge clk); #1;
    a_write = 1'b1; a_din = 32'hA5A5A5A5; qa.push_back(a_din);
    @(posedge clk); #1;
    a_write = 1'b0;
    check("one_empty_n", a_empty_n, 1);
    check("one_dout", a_dout, 32'hA5A5A5A5);
    check("one_count", a_count, 1);
    a_read = 1'b1;
    @(posedge clk); #1;
    a_read = 1'b0;
    check("one_drained", a_count, 0);

    // Fill 0..31; almost-full at 30, writes still accepted to 32.
    for (int i = 0; i < 32; i++) begin
      a_write = 1'b1; a_din = i; qa.push_back(a_din);
      @(posedge clk); #1;
      check("fill_count", a_count, i + 1);
      check("fill_full_n", a_full_n, (i + 1) < 30);
    end
    a_din = 32'h99;
    @(posedge clk); #1;
    a_write = 1'b0;
    check("drop_count", a_count, 32);
`ifdef FIFO_OVERFLOW_CHECK_EN
    check("drop_overflow", a_overflow, 1);
`else
    check("drop_overflow", a_overflow, 0);
`endif

    // Drain full FIFO back to back.
    a_read = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      check("drain_count", a_count, 31 - i);
      check("drain_full_n", a_full_n, (31 - i) < 30);
      check("drain_empty_n", a_empty_n, i != 31);
    end
    @(posedge clk); #1;
    a_read = 1'b0;
    check("empty_read_count", a_count, 0);
    check("empty_read_dout", a_dout, 0);

    // Clock-enable gating.
    a_write = 1'b1;
    for (int i = 10; i < 13; i++) begin
      a_din = i; qa.push_back(a_din);
      @(posedge clk); #1;
    end
    a_write_ce = 1'b0; a_din = 32'h77;
    repeat (4) begin
      @(posedge clk); #1;
      check("wce_count", a_count, 3);
    end
    a_write = 1'b0; a_write_ce = 1'b1;
    a_read_ce = 1'b0; a_read = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("rce_count", a_count, 3);
      check("rce_dout", a_dout, 10);
    end
    a_read = 1'b0; a_read_ce = 1'b1;

    // Bring count to 7, then reset asynchronously between edges.
    a_write = 1'b1;
    for (int i = 13; i < 17; i++) begin
      a_din = i; qa.push_back(a_din);
      @(posedge clk); #1;
    end
    a_write = 1'b0;
    check("pre_rst_count", a_count, 7);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("async_empty_n", a_empty_n, 0);
    check("async_count", a_count, 0);
    check("async_overflow", a_overflow, 0);
    qa.delete();
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    a_write = 1'b1; a_din = 32'h1; qa.push_back(a_din);
    @(posedge clk); #1;
    a_write = 1'b0;
    check("post_rst_count", a_count, 1);
    a_read = 1'b1;
    @(posedge clk); #1;
    a_read = 1'b0;
    check("post_rst_drained", a_count, 0);

    // DEPTH=5: prefill 3, then simultaneous read/write through several wraps.
    b_write = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_din = i; qb.push_back(b_din);
      b_read = (i >= 3);
      @(posedge clk); #1;
      if (i >= 2) begin
        check("b_count_steady", b_count, 3);
        check("b_full_n", b_full_n, 1);
      end
    end
    b_write = 1'b0; b_read = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    b_read = 1'b0;
    check("b_end_count", b_count, 0);
    check("b_end_empty_n", b_empty_n, 0);

    @(posedge clk); #1;
    check("qa_left", qa.size(), 0);
    check("qb_left", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
